// File: rtl/data_sync_tx_if.sv
// Handshake and bus bundle between local logic / destination domain and the data_sync_tx launcher.
interface data_sync_tx_if #(
  parameter int BUS_WIDTH = 8
);
  logic [BUS_WIDTH-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic [BUS_WIDTH-1:0] unsync_bus;
  logic                 bus_enable;
  logic                 ack_async;

  // master: upstream word source plus destination acknowledge; slave: the launcher
  modport master (
    output in_data,
    output in_valid,
    output ack_async,
    input  in_ready,
    input  unsync_bus,
    input  bus_enable
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  ack_async,
    output in_ready,
    output unsync_bus,
    output bus_enable
  );
endinterface

// File: rtl/data_sync_tx.sv
// Source-domain launcher for a multi-flop bus synchronizer using a 4-phase req/ack handshake.
// Optional request timeout compiled in with `define DATA_SYNC_TX_TIMEOUT_EN.
module data_sync_tx #(
  parameter int BUS_WIDTH      = 8,
  parameter int NUM_STAGES     = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  data_sync_tx_if.slave     bus,
  output logic              busy,
  output logic              timeout_err
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_REQ      = 2'd1;
  localparam logic [1:0] ST_WAIT_LOW = 2'd2;

  logic [1:0]            state_reg;
  logic [1:0]            state_next;
  logic [BUS_WIDTH-1:0]  data_reg;
  logic [BUS_WIDTH-1:0]  data_next;
  logic                  enable_reg;
  logic                  enable_next;
  logic [NUM_STAGES-1:0] ack_sync_reg;
  logic                  ack_sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_sync_reg <= '0;
    end else begin
      ack_sync_reg <= {ack_sync_reg[NUM_STAGES-2:0], bus.ack_async};
    end
  end

  assign ack_sync = ack_sync_reg[NUM_STAGES-1];

`ifdef DATA_SYNC_TX_TIMEOUT_EN
  localparam int             CNT_W     = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             err_reg;
  logic             err_next;

  // Counter is held at zero outside REQ, so it is already cleared on the accepting edge.
  assign cnt_next = (state_reg == ST_REQ) ? cnt_reg + CNT_W'(1) : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
      err_reg <= 1'b0;
    end else begin
      cnt_reg <= cnt_next;
      err_reg <= err_next;
    end
  end

  assign timeout_err = err_reg;
`else
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_next  = state_reg;
    data_next   = data_reg;
    enable_next = enable_reg;
`ifdef DATA_SYNC_TX_TIMEOUT_EN
    err_next    = 1'b0;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (bus.in_valid) begin
          data_next   = bus.in_data;
          enable_next = 1'b1;
          state_next  = ST_REQ;
        end
      end
      ST_REQ: begin
        // An acknowledge arriving on the limit cycle takes priority over the timeout.
        if (ack_sync) begin
          enable_next = 1'b0;
          state_next  = ST_WAIT_LOW;
        end
`ifdef DATA_SYNC_TX_TIMEOUT_EN
        else if (cnt_reg == CNT_LIMIT) begin
          enable_next = 1'b0;
          state_next  = ST_WAIT_LOW;
          err_next    = 1'b1;
        end
`endif
      end
      ST_WAIT_LOW: begin
        if (!ack_sync) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        enable_next = 1'b0;
        state_next  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= ST_IDLE;
      data_reg   <= '0;
      enable_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      data_reg   <= data_next;
      enable_reg <= enable_next;
    end
  end

  assign bus.unsync_bus = data_reg;
  assign bus.bus_enable = enable_reg;
  assign bus.in_ready   = (state_reg == ST_IDLE);
  assign busy           = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_data_sync_tx.sv
// Self-checking bench for data_sync_tx: vector table of loopback transfers plus hand-written corner sequences.
module tb_data_sync_tx;
  localparam int BW = 8;
  localparam int NS = 2;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy;
  logic timeout_err;
  logic loop_mode = 1'b1;
  logic ack_man   = 1'b0;

  always #5 clk = ~clk;

  data_sync_tx_if #(.BUS_WIDTH(BW)) bus_if ();

  assign bus_if.ack_async = loop_mode ? bus_if.bus_enable : ack_man;

  data_sync_tx #(
    .BUS_WIDTH      (BW),
    .NUM_STAGES     (NS),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus_if.slave),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  int checks = 0;
  int errors = 0;
  logic [BW-1:0] sb_q[$];
  int xfer_num = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Scoreboard: each rising request must carry the next expected word and hold it while high.
  initial begin : monitor
    logic          prev_en;
    logic [BW-1:0] held;
    logic [BW-1:0] exp_word;
    prev_en = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      if (bus_if.bus_enable && !prev_en) begin
        xfer_num++;
        $display("xfer %0d: bus=%02h at %0t", xfer_num, bus_if.unsync_bus, $time);
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_request: got bus=%02h, required no request", bus_if.unsync_bus);
        end else begin
          exp_word = sb_q.pop_front();
          check("launch_bus", bus_if.unsync_bus, exp_word);
        end
        held = bus_if.unsync_bus;
      end else if (bus_if.bus_enable && prev_en) begin
        check("bus_stable", bus_if.unsync_bus, held);
      end
      prev_en = bus_if.bus_enable;
    end
  end

  // Called #1 after an edge; returns #1 after the accepting edge.
  task automatic accept(input logic [BW-1:0] d, input logic [BW-1:0] exp, input bit hold);
    int n;
    n = 0;
    while (!bus_if.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) check("ready_wait_timeout", 0, 1);
    bus_if.in_data  = d;
    bus_if.in_valid = 1'b1;
    sb_q.push_back(exp);
    @(posedge clk); #1;
    if (!hold) bus_if.in_valid = 1'b0;
  endtask

  // Sample index i is taken #1 after edge (start + i).
  task automatic measure(input int budget, output int en_cnt, output int rdy_edge, output int err_cnt);
    en_cnt   = 0;
    rdy_edge = -1;
    err_cnt  = 0;
    for (int i = 0; i < budget; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      en_cnt  += int'(bus_if.bus_enable);
      err_cnt += int'(timeout_err);
      if (bus_if.in_ready) begin
        rdy_edge = i;
        break;
      end
    end
  endtask

  typedef struct {
    logic [BW-1:0] din;
    logic [BW-1:0] exp_bus;
    int            exp_en;
    int            exp_rdy;
  } vec_t;

  vec_t vecs[4];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int en_cnt;
    int rdy;
    int err_cnt;
    int fall;

    vecs[0] = '{8'b10010011, 8'h93, NS + 1, 2 * NS + 2};
    vecs[1] = '{8'hA5,       8'hA5, NS + 1, 2 * NS + 2};
    vecs[2] = '{8'h00,       8'h00, NS + 1, 2 * NS + 2};
    vecs[3] = '{8'hFF,       8'hFF, NS + 1, 2 * NS + 2};

    bus_if.in_data  = 8'h55;
    bus_if.in_valid = 1'b1;

    // Reset state, with a word offered that must not be taken
    repeat (3) @(posedge clk);
    #1;
    check("rst_bus_enable", bus_if.bus_enable, 0);
    check("rst_unsync_bus", bus_if.unsync_bus, 0);
    check("rst_in_ready", bus_if.in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_timeout_err", timeout_err, 0);
    bus_if.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("post_rst_idle", bus_if.in_ready, 1);

    // Loopback table
    for (int v = 0; v < 4; v++) begin
      accept(vecs[v].din, vecs[v].exp_bus, 1'b0);
      measure(30, en_cnt, rdy, err_cnt);
      check("tbl_enable_cycles", en_cnt, vecs[v].exp_en);
      check("tbl_ready_return", rdy, vecs[v].exp_rdy);
      check("tbl_bus_held_idle", bus_if.unsync_bus, vecs[v].exp_bus);
      check("tbl_busy_idle", busy, 0);
    end

    // Back-to-back with in_valid held
    accept(8'hEB, 8'hEB, 1'b1);
    bus_if.in_data = 8'h38;
    sb_q.push_back(8'h38);
    measure(30, en_cnt, rdy, err_cnt);
    check("b2b_first_ready_return", rdy, 2 * NS + 2);
    @(posedge clk); #1;
    check("b2b_second_accept_enable", bus_if.bus_enable, 1);
    check("b2b_second_accept_busy", busy, 1);
    bus_if.in_valid = 1'b0;
    measure(30, en_cnt, rdy, err_cnt);
    check("b2b_second_enable_cycles", en_cnt, NS + 1);
    check("b2b_second_ready_return", rdy, 2 * NS + 2);
    check("b2b_second_bus", bus_if.unsync_bus, 8'h38);

    // Valid pulsed during REQ is ignored
    accept(8'h93, 8'h93, 1'b0);
    @(posedge clk); #1;
    bus_if.in_data  = 8'hFF;
    bus_if.in_valid = 1'b1;
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
    check("ign_bus_in_req", bus_if.unsync_bus, 8'h93);
    measure(30, en_cnt, rdy, err_cnt);
    check("ign_ready_return", rdy, 2 * NS);
    repeat (4) @(posedge clk);
    #1;
    check("ign_no_extra_request", bus_if.bus_enable, 0);
    check("ign_bus_kept", bus_if.unsync_bus, 8'h93);

    // Delayed acknowledge driven by hand
    loop_mode = 1'b0;
    ack_man   = 1'b0;
    accept(8'h5C, 8'h5C, 1'b0);
    en_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      en_cnt += int'(bus_if.bus_enable);
    end
    check("dly_enable_held", en_cnt, 20);
    ack_man = 1'b1;
    fall = -1;
    rdy  = -1;
    for (int j = 1; j <= 12; j++) begin
      @(posedge clk); #1;
      if (fall < 0 && !bus_if.bus_enable) fall = j;
      if (rdy < 0 && bus_if.in_ready) rdy = j;
      if (j == 5) ack_man = 1'b0;
    end
    check("dly_enable_fall", fall, NS + 1);
    check("dly_ready_rise", rdy, 5 + NS + 1);
    loop_mode = 1'b1;

    // Asynchronous reset during REQ
    accept(8'hAA, 8'hAA, 1'b0);
    @(posedge clk); #1;
    check("mid_rst_in_req", bus_if.bus_enable, 1);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_enable_clear", bus_if.bus_enable, 0);
    check("mid_rst_bus_clear", bus_if.unsync_bus, 0);
    check("mid_rst_ready", bus_if.in_ready, 1);
    check("mid_rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_release_ready", bus_if.in_ready, 1);
    check("mid_rst_release_enable", bus_if.bus_enable, 0);
    accept(8'h4D, 8'h4D, 1'b0);
    measure(30, en_cnt, rdy, err_cnt);
    check("recover_ready_return", rdy, 2 * NS + 2);

    // Request with acknowledge stuck low
    loop_mode = 1'b0;
    ack_man   = 1'b0;
    accept(8'h3C, 8'h3C, 1'b0);
    measure(40, en_cnt, rdy, err_cnt);
`ifdef DATA_SYNC_TX_TIMEOUT_EN
    check("to_enable_cycles", en_cnt, TO);
    check("to_err_pulses", err_cnt, 1);
    check("to_ready_return", rdy, TO + 1);
`else
    check("noto_enable_cycles", en_cnt, 40);
    check("noto_err_pulses", err_cnt, 0);
    check("noto_still_busy", rdy, -1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
`endif
    loop_mode = 1'b1;
    @(posedge clk); #1;
    check("final_idle", bus_if.in_ready, 1);
    check("scoreboard_drained", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
